// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller.
//   hazState_e     : stall sequencer states
//   FWD_*          : per-operand forwarding select encodings
//   DEFAULT_REG_AW : default register-address width
//   isAsserted()   : enable qualification (only a clean 1 counts)
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LSTALL = 2'd1,
        BUSY   = 2'd2
    } hazState_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam int DEFAULT_REG_AW = 5;

    // An X or Z on a write enable must never produce a forward, so only
    // an exact 1 is accepted.
    function automatic logic isAsserted(input logic en);
        return (en === 1'b1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding select for one ID source operand.
//   srcReg/srcUsed        : operand register and whether it is read
//   enEx/enMem/enWb       : qualified RF write enables of later stages
//   regEx/regMem/regWb    : destination registers of later stages
//   sel                   : FWD_RF / FWD_EX / FWD_MEM / FWD_WB
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic [REG_AW-1:0] srcReg,
    input  logic              srcUsed,
    input  logic              enEx,
    input  logic              enMem,
    input  logic              enWb,
    input  logic [REG_AW-1:0] regEx,
    input  logic [REG_AW-1:0] regMem,
    input  logic [REG_AW-1:0] regWb,
    output logic [1:0]        sel
);

    // Register 0 is hard-wired zero, so it is never forwarded.
    logic candidate;
    assign candidate = srcUsed && (srcReg != '0);

    // Youngest producer wins: EX, then MEM, then WB.
    always_comb begin
        sel = FWD_RF;
        if (candidate && enEx && (srcReg == regEx)) begin
            sel = FWD_EX;
        end else if (candidate && enMem && (srcReg == regMem)) begin
            sel = FWD_MEM;
        end else if (candidate && enWb && (srcReg == regWb)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard unit: per-operand forwarding selects, load-use and
// multi-cycle-EX stall sequencing, branch flush of IF/ID and a saturating
// count of stalled cycles.
//   clk, reset_n                 : clock, async active-low reset
//   enable_*/reg_*/load_ex       : producer info from EX/MEM/WB
//   src_reg/src_used             : ID operand registers and use flags
//   ex_busy, branch_taken        : multi-cycle EX op, resolved taken branch
//   stat_clr                     : synchronous clear of stall_cycles
//   fwd_sel                      : 2 bits per operand (RF/EX/MEM/WB)
//   pc_le/npc_le/ifid_le         : front-end load enables (always equal)
//   nop_sel, ifid_flush          : bubble injection, IF/ID clear
//   stall_cycles                 : cycles with pc_le=0, saturating
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW     = DEFAULT_REG_AW,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable_ex,
    input  logic                      enable_mem,
    input  logic                      enable_wb,
    input  logic                      load_ex,
    input  logic [REG_AW-1:0]         reg_ex,
    input  logic [REG_AW-1:0]         reg_mem,
    input  logic [REG_AW-1:0]         reg_wb,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic                      ex_busy,
    input  logic                      branch_taken,
    input  logic                      stat_clr,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      pc_le,
    output logic                      npc_le,
    output logic                      ifid_le,
    output logic                      nop_sel,
    output logic                      ifid_flush,
    output logic [CNT_W-1:0]          stall_cycles
);

    // Remaining-bubble counter width; LOAD_STALL-2 always fits.
    localparam int LCW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL + 1) : 1;
    localparam logic [LCW-1:0] LSTALL_LOAD = LCW'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);

    logic enEx, enMem, enWb;
    assign enEx  = isAsserted(enable_ex);
    assign enMem = isAsserted(enable_mem);
    assign enWb  = isAsserted(enable_wb);

    logic [NUM_SRC*2-1:0] fwdRaw;
    logic [NUM_SRC-1:0]   srcHit;
    logic                 loadUseHit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        fwd_select #(.REG_AW(REG_AW)) uFwd (
            .srcReg  (src_reg[i*REG_AW +: REG_AW]),
            .srcUsed (src_used[i]),
            .enEx    (enEx),
            .enMem   (enMem),
            .enWb    (enWb),
            .regEx   (reg_ex),
            .regMem  (reg_mem),
            .regWb   (reg_wb),
            .sel     (fwdRaw[2*i +: 2])
        );
        // Load-use ignores enable_ex: a load always writes its destination.
        assign srcHit[i] = src_used[i]
                        && (src_reg[i*REG_AW +: REG_AW] == reg_ex)
                        && (src_reg[i*REG_AW +: REG_AW] != '0);
    end

    assign loadUseHit = load_ex && (|srcHit);

    hazState_e      state, stateNext;
    logic [LCW-1:0] cnt, cntNext;
    logic           leComb, nopComb, flushComb;
    logic [CNT_W-1:0] statReg;

    // Outputs must react to the hazard in the same cycle it appears, so
    // they are decoded from the registered state plus the current inputs.
    // BUSY with ex_busy low falls through to the IDLE rules, giving no
    // dead cycle when the EX op completes.
    always_comb begin
        leComb    = 1'b1;
        nopComb   = 1'b0;
        flushComb = 1'b0;
        stateNext = IDLE;
        cntNext   = cnt;
        if (ex_busy) begin
            leComb    = 1'b0;
            stateNext = BUSY;
            cntNext   = '0;         // any pending load bubble is dropped
        end else if (branch_taken) begin
            flushComb = 1'b1;
            cntNext   = '0;         // branch aborts a pending load bubble
        end else if (state == LSTALL) begin
            leComb  = 1'b0;
            nopComb = 1'b1;
            if (cnt != '0) begin
                stateNext = LSTALL;
                cntNext   = cnt - LCW'(1);
            end
        end else if (loadUseHit) begin
            leComb  = 1'b0;
            nopComb = 1'b1;
            // First bubble is this cycle; LSTALL supplies the other LOAD_STALL-1.
            if (LOAD_STALL > 1) begin
                stateNext = LSTALL;
                cntNext   = LSTALL_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            statReg <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (stat_clr) begin
                statReg <= '0;
            end else if (!leComb && (statReg != '1)) begin
                statReg <= statReg + CNT_W'(1);
            end
        end
    end

    // Reset forces the pipeline-transparent output values.
    assign pc_le        = leComb | ~reset_n;
    assign npc_le       = pc_le;
    assign ifid_le      = pc_le;
    assign nop_sel      = nopComb & reset_n;
    assign ifid_flush   = flushComb & reset_n;
    assign fwd_sel      = reset_n ? fwdRaw : '0;
    assign stall_cycles = statReg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    // Three instances share every input: u0 LOAD_STALL=1, u1 LOAD_STALL=3,
    // u2 LOAD_STALL=1 with a 2-bit statistic counter.
    localparam int NI = 3;
    localparam int LS [NI] = '{1, 3, 1};
    localparam int CW [NI] = '{16, 16, 2};

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        enableEx, enableMem, enableWb, loadEx;
    logic [4:0]  regEx, regMem, regWb;
    logic [9:0]  srcReg;
    logic [1:0]  srcUsed;
    logic        exBusy, branchTaken, statClr;

    logic [3:0]  fwd0, fwd1, fwd2;
    logic [NI-1:0] pcLe, npcLe, ifidLe, nopSel, flush;
    logic [15:0] stat0, stat1;
    logic [1:0]  stat2;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.LOAD_STALL(1), .CNT_W(16)) u0 (
        .clk(clk), .reset_n(resetN), .enable_ex(enableEx), .enable_mem(enableMem),
        .enable_wb(enableWb), .load_ex(loadEx), .reg_ex(regEx), .reg_mem(regMem),
        .reg_wb(regWb), .src_reg(srcReg), .src_used(srcUsed), .ex_busy(exBusy),
        .branch_taken(branchTaken), .stat_clr(statClr), .fwd_sel(fwd0),
        .pc_le(pcLe[0]), .npc_le(npcLe[0]), .ifid_le(ifidLe[0]), .nop_sel(nopSel[0]),
        .ifid_flush(flush[0]), .stall_cycles(stat0));

    hazard_stall_controller #(.LOAD_STALL(3), .CNT_W(16)) u1 (
        .clk(clk), .reset_n(resetN), .enable_ex(enableEx), .enable_mem(enableMem),
        .enable_wb(enableWb), .load_ex(loadEx), .reg_ex(regEx), .reg_mem(regMem),
        .reg_wb(regWb), .src_reg(srcReg), .src_used(srcUsed), .ex_busy(exBusy),
        .branch_taken(branchTaken), .stat_clr(statClr), .fwd_sel(fwd1),
        .pc_le(pcLe[1]), .npc_le(npcLe[1]), .ifid_le(ifidLe[1]), .nop_sel(nopSel[1]),
        .ifid_flush(flush[1]), .stall_cycles(stat1));

    hazard_stall_controller #(.LOAD_STALL(1), .CNT_W(2)) u2 (
        .clk(clk), .reset_n(resetN), .enable_ex(enableEx), .enable_mem(enableMem),
        .enable_wb(enableWb), .load_ex(loadEx), .reg_ex(regEx), .reg_mem(regMem),
        .reg_wb(regWb), .src_reg(srcReg), .src_used(srcUsed), .ex_busy(exBusy),
        .branch_taken(branchTaken), .stat_clr(statClr), .fwd_sel(fwd2),
        .pc_le(pcLe[2]), .npc_le(npcLe[2]), .ifid_le(ifidLe[2]), .nop_sel(nopSel[2]),
        .ifid_flush(flush[2]), .stall_cycles(stat2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // remBubbles: bubble cycles still owed after the current one.
    int remBubbles [NI] = '{0, 0, 0};
    int modelStat  [NI] = '{0, 0, 0};

    typedef struct packed {
        logic       le;
        logic       nop;
        logic       flush;
        logic [3:0] fwd;
    } exp_t;

    function automatic logic [1:0] fwdOf(input int s);
        logic [4:0] r;
        r = srcReg[s*5 +: 5];
        if (srcUsed[s] !== 1'b1 || r == 5'd0) return 2'b00;
        if (enableEx === 1'b1 && r == regEx) return 2'b01;
        if (enableMem === 1'b1 && r == regMem) return 2'b10;
        if (enableWb === 1'b1 && r == regWb) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic useHit();
        logic hit = 1'b0;
        for (int s = 0; s < 2; s++)
            if (srcUsed[s] && srcReg[s*5 +: 5] == regEx && srcReg[s*5 +: 5] != 5'd0) hit = 1'b1;
        return loadEx && hit;
    endfunction

    function automatic exp_t modelOut(input int rem);
        exp_t e;
        e = '{le: 1'b1, nop: 1'b0, flush: 1'b0, fwd: 4'h0};
        if (resetN !== 1'b1) return e;
        e.fwd = {fwdOf(1), fwdOf(0)};
        if (exBusy) e.le = 1'b0;
        else if (branchTaken) e.flush = 1'b1;
        else if (rem > 0 || useHit()) begin
            e.le  = 1'b0;
            e.nop = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NI; i++) begin
                remBubbles[i] <= 0;
                modelStat[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                exp_t e;
                int maxStat;
                e = modelOut(remBubbles[i]);
                maxStat = (1 << CW[i]) - 1;
                if (exBusy || branchTaken) remBubbles[i] <= 0;
                else if (remBubbles[i] > 0) remBubbles[i] <= remBubbles[i] - 1;
                else if (useHit()) remBubbles[i] <= LS[i] - 1;
                if (statClr) modelStat[i] <= 0;
                else if (!e.le && modelStat[i] < maxStat) modelStat[i] <= modelStat[i] + 1;
            end
        end
    end

    function automatic logic [3:0] fwdOfInst(input int i);
        return (i == 0) ? fwd0 : (i == 1) ? fwd1 : fwd2;
    endfunction

    function automatic logic [15:0] statOfInst(input int i);
        return (i == 0) ? stat0 : (i == 1) ? stat1 : {14'd0, stat2};
    endfunction

    // Compare process: every negedge, every instance, every output.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e = modelOut(remBubbles[i]);
            check($sformatf("u%0d fwd_sel", i), 32'(fwdOfInst(i)), 32'(e.fwd));
            check($sformatf("u%0d pc_le", i), 32'(pcLe[i]), 32'(e.le));
            check($sformatf("u%0d npc_le", i), 32'(npcLe[i]), 32'(e.le));
            check($sformatf("u%0d ifid_le", i), 32'(ifidLe[i]), 32'(e.le));
            check($sformatf("u%0d nop_sel", i), 32'(nopSel[i]), 32'(e.nop));
            check($sformatf("u%0d ifid_flush", i), 32'(flush[i]), 32'(e.flush));
            check($sformatf("u%0d stall_cycles", i), 32'(statOfInst(i)), 32'(modelStat[i]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        enableEx = 0; enableMem = 0; enableWb = 0; loadEx = 0;
        regEx = 0; regMem = 0; regWb = 0; srcReg = 0; srcUsed = 0;
        exBusy = 0; branchTaken = 0; statClr = 0;
    endtask

    task automatic setLoadHazard();
        enableEx = 1; loadEx = 1; regEx = 5'd5;
        srcReg = {5'd5, 5'd0}; srcUsed = 2'b11;
    endtask

    initial begin
        clearInputs();
        resetN = 0;
        tick(2);
        check("rst pc_le", 32'(pcLe[0]), 32'd1);
        check("rst nop_sel", 32'(nopSel[0]), 32'd0);
        check("rst stall_cycles", 32'(stat0), 32'd0);
        resetN = 1;
        tick(1);

        // Forwarding priority
        enableEx = 1; enableMem = 1; regEx = 5'd8; regMem = 5'd8;
        srcReg = {5'd0, 5'd8}; srcUsed = 2'b11;
        #1 check("fwd ex wins", 32'(fwd0[1:0]), 32'h1);
        enableEx = 0;
        #1 check("fwd mem", 32'(fwd0[1:0]), 32'h2);
        srcReg = 10'd0; regWb = 5'd0; enableWb = 1;
        #1 check("fwd r0", 32'(fwd0[1:0]), 32'h0);
        tick(1);
        clearInputs();
        statClr = 1;
        tick(1);
        statClr = 0;

        // Load-use: one bubble for u0/u2, three for u1
        setLoadHazard();
        #1;
        check("lu u0 pc_le", 32'(pcLe[0]), 32'd0);
        check("lu u0 nop_sel", 32'(nopSel[0]), 32'd1);
        check("lu u1 pc_le", 32'(pcLe[1]), 32'd0);
        tick(1);
        loadEx = 0;
        #1;
        check("lu u0 resumes", 32'(pcLe[0]), 32'd1);
        check("lu u1 second bubble", 32'(nopSel[1]), 32'd1);
        tick(2);
        check("lu u1 resumes", 32'(pcLe[1]), 32'd1);
        check("lu u0 stat", 32'(stat0), 32'd1);
        check("lu u1 stat", 32'(stat1), 32'd3);
        check("lu u2 stat", 32'(stat2), 32'd1);

        // Hazard on an unused source: no stall
        loadEx = 1; srcUsed = 2'b01;
        #1 check("unused src no stall", 32'(pcLe[0]), 32'd1);
        tick(1);
        loadEx = 0;

        // Branch abort of u1's long bubble
        setLoadHazard();
        tick(1);
        loadEx = 0; branchTaken = 1;
        #1;
        check("abort flush", 32'(flush[1]), 32'd1);
        check("abort pc_le", 32'(pcLe[1]), 32'd1);
        check("abort nop_sel", 32'(nopSel[1]), 32'd0);
        tick(1);
        branchTaken = 0;
        #1;
        check("post abort pc_le", 32'(pcLe[1]), 32'd1);
        check("post abort nop", 32'(nopSel[1]), 32'd0);

        // Busy for 4 cycles, load-use present when it drops
        clearInputs();
        statClr = 1;
        tick(1);
        statClr = 0;
        setLoadHazard();
        exBusy = 1;
        #1;
        check("busy pc_le", 32'(pcLe[0]), 32'd0);
        check("busy nop_sel", 32'(nopSel[0]), 32'd0);
        tick(4);
        exBusy = 0;
        #1;
        check("post busy bubble u0", 32'(nopSel[0]), 32'd1);
        check("post busy bubble u1", 32'(nopSel[1]), 32'd1);
        tick(1);
        loadEx = 0;
        #1;
        check("busy+bubble u0 stat", 32'(stat0), 32'd5);
        check("u1 in lstall", 32'(nopSel[1]), 32'd1);
        // Asynchronous reset in the middle of u1's bubble
        resetN = 0;
        #1;
        check("async rst pc_le", 32'(pcLe[1]), 32'd1);
        check("async rst nop", 32'(nopSel[1]), 32'd0);
        check("async rst stat", 32'(stat1), 32'd0);
        tick(2);
        resetN = 1;
        tick(1);

        // X on an enable must not forward
        clearInputs();
        enableEx = 1'bx; regEx = 5'd9; srcReg = {5'd0, 5'd9}; srcUsed = 2'b01;
        tick(2);
        clearInputs();

        // Saturation of the 2-bit counter
        statClr = 1;
        tick(1);
        statClr = 0;
        exBusy = 1;
        tick(5);
        exBusy = 0;
        #1;
        check("sat u2 stat", 32'(stat2), 32'd3);
        check("nosat u0 stat", 32'(stat0), 32'd5);
        statClr = 1;
        tick(1);
        statClr = 0;
        check("clr u2 stat", 32'(stat2), 32'd0);
        check("clr u0 stat", 32'(stat0), 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
